// File: rtl/ctr_sched_pkg.sv
// ctr_sched_pkg: shared state encoding and op codes for the counter scheduler
package ctr_sched_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, INCR, DONE} state_t;
   localparam logic OP_LOAD = 1'b0;
   localparam logic OP_INCR = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority grant, search starts just after ptr
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any_valid
);
   logic [IDW-1:0] j;
   always_comb begin
      grant = '0;
      idx = '0;
      any_valid = 1'b0;
      j = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = IDW'((int'(ptr) + k) % NREQ);
         if (!any_valid && req[j]) begin
            any_valid = 1'b1;
            idx = j;
         end
      end
      grant[idx] = any_valid;
   end
endmodule

// File: rtl/ctr_rr_scheduler.sv
// ctr_rr_scheduler: round-robin sharing of one loadable up-counter among NREQ requesters
module ctr_rr_scheduler
   import ctr_sched_pkg::*;
#(
   parameter int N = 8,
   parameter int NREQ = 4,
   parameter int LW = 4,
   parameter int IDW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_op,
   input  logic [NREQ*N-1:0] req_arg,
   output logic [NREQ-1:0]   req_ready,
   output logic              ctr_cmd,
   output logic [N-1:0]      ctr_data,
   input  logic [N-1:0]      ctr_dout,
   output logic              busy,
   output logic              done,
   output logic [IDW-1:0]    done_id,
   output logic [N-1:0]      result
);
   state_t state, state_n;
   logic [IDW-1:0] ptr, id_q, widx;
   logic [N-1:0] arg_q, warg, ctr_next;
   logic [LW-1:0] rem;
   logic [NREQ-1:0] grant;
   logic any_valid, take, wop;
   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req(req_valid), .ptr(ptr), .grant(grant), .idx(widx), .any_valid(any_valid)
   );
   assign take = state == IDLE && any_valid && !rst;
   assign wop = req_op[widx];
   assign warg = req_arg[widx*N +: N];
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = !take ? IDLE : wop == OP_LOAD ? LOAD : warg[LW-1:0] == '0 ? DONE : INCR;
         LOAD: state_n = DONE;
         INCR: state_n = rem == LW'(1) ? DONE : INCR;
         default: state_n = IDLE;
      endcase
   end
   // idle/done and reset hold the counter by feeding its own value back
   always_comb begin
      req_ready = take ? grant : '0;
      ctr_cmd = !rst && state == INCR;
      ctr_data = rst ? ctr_dout : state == LOAD ? arg_q : state == INCR ? '0 : ctr_dout;
      busy = state != IDLE;
      ctr_next = ctr_cmd ? ctr_dout + N'(1) : ctr_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= IDW'(NREQ - 1);
         id_q <= '0;
         arg_q <= '0;
         rem <= '0;
         done <= 1'b0;
         done_id <= '0;
         result <= '0;
      end else begin
         state <= state_n;
         if (take) begin
            ptr <= widx;
            id_q <= widx;
            arg_q <= warg;
            rem <= wop == OP_INCR ? warg[LW-1:0] : '0;
         end else if (state == INCR) begin
            rem <= rem - 1'b1;
         end
         // result captures what the counter holds once it settles in DONE
         done <= state_n == DONE;
         if (state_n == DONE) begin
            done_id <= take ? widx : id_q;
            result <= ctr_next;
         end
      end
   end
endmodule

// File: tb/tb_ctr_rr_scheduler.sv
// tb_ctr_rr_scheduler: scoreboarded bench with a behavioural counter on the scheduler pins
module tb_ctr_rr_scheduler;
   import ctr_sched_pkg::*;
   localparam int N = 8, NREQ = 4, LW = 4, IDW = 2;
   typedef struct {logic [IDW-1:0] id; logic [N-1:0] val;} exp_t;
   logic clk = 1'b0, rst = 1'b1, rst_n;
   logic [NREQ-1:0] req_valid, req_op, req_ready;
   logic [NREQ*N-1:0] req_arg;
   logic ctr_cmd, busy, done;
   logic [N-1:0] ctr_data, cnt, result;
   logic [IDW-1:0] done_id;
   int compared = 0, mismatched = 0;
   exp_t sbq[$];
   exp_t e;
   always #5 clk = ~clk;
   assign rst_n = ~rst;
   ctr_rr_scheduler #(.N(N), .NREQ(NREQ), .LW(LW), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_arg(req_arg),
      .req_ready(req_ready), .ctr_cmd(ctr_cmd), .ctr_data(ctr_data), .ctr_dout(cnt),
      .busy(busy), .done(done), .done_id(done_id), .result(result)
   );
   // sandbox counter: cmd=0 load, cmd=1 increment, async active-low reset
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= ctr_cmd ? cnt + 8'd1 : ctr_data;
   always @(negedge clk)
      if (done) begin
         compared++;
         if (sbq.size() == 0) begin
            mismatched++;
            $display("FAIL done_unexpected: got id=%0d result=%02h, required no done", done_id, result);
         end else begin
            e = sbq.pop_front();
            if (done_id !== e.id || result !== e.val) begin
               mismatched++;
               $display("FAIL done_result: got id=%0d result=%02h, required id=%0d result=%02h",
                        done_id, result, e.id, e.val);
            end
         end
      end
   task automatic post(input int id, input logic op, input logic [N-1:0] arg);
      req_valid[id] = 1'b1;
      req_op[id] = op;
      req_arg[id*N +: N] = arg;
   endtask
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_ready(output logic [NREQ-1:0] g);
      g = '0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            g = req_ready;
            break;
         end
      end
   endtask
   task automatic wait_done(input logic [NREQ-1:0] drop, output int n, output int cmds);
      n = -1;
      cmds = 0;
      for (int t = 1; t <= 40; t++) begin
         edge1();
         if (t == 1) req_valid &= ~drop;
         @(negedge clk);
         cmds += int'(ctr_cmd);
         if (done) begin
            n = t;
            break;
         end
      end
   endtask
   task automatic drain();
      for (int t = 0; t < 100 && sbq.size() != 0; t++) @(negedge clk);
      compared++;
      if (sbq.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d outstanding, required 0", sbq.size());
      end
   endtask
   task automatic test_reset();
      req_valid = '0;
      req_op = '0;
      req_arg = '0;
      rst = 1'b1;
      post(0, OP_LOAD, 8'h5A);
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++;
      if (req_ready !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b, required 0000 0 0", req_ready, busy, done);
      end
      compared++;
      if (result !== 8'h00 || ctr_cmd !== 1'b0 || ctr_data !== cnt) begin
         mismatched++;
         $display("FAIL reset_pins: got result=%02h cmd=%b data=%02h, required 00 0 %02h", result, ctr_cmd, ctr_data, cnt);
      end
      edge1();
      req_valid = '0;
      rst = 1'b0;
   endtask
   task automatic test_load();
      logic [NREQ-1:0] g;
      int n, c;
      bit ok = 1'b1;
      edge1();
      post(0, OP_LOAD, 8'h5A);
      sbq.push_back('{2'd0, 8'h5A});
      wait_ready(g);
      compared++;
      if (g !== 4'b0001) begin
         mismatched++;
         $display("FAIL load_grant: got %b, required 0001", g);
      end
      wait_done(4'b0001, n, c);
      compared++;
      if (n != 2) begin
         mismatched++;
         $display("FAIL load_latency: got %0d, required 2", n);
      end
      repeat (10) begin
         @(negedge clk);
         if (cnt !== 8'h5A || busy !== 1'b0 || ctr_cmd !== 1'b0 || ctr_data !== cnt) ok = 1'b0;
      end
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL idle_hold: got cnt=%02h busy=%b cmd=%b, required 5a 0 0", cnt, busy, ctr_cmd);
      end
   endtask
   task automatic test_incr();
      logic [NREQ-1:0] g;
      int n, c;
      edge1();
      post(1, OP_LOAD, 8'h10);
      sbq.push_back('{2'd1, 8'h10});
      wait_ready(g);
      wait_done(4'b0010, n, c);
      edge1();
      post(2, OP_INCR, 8'hA3);
      sbq.push_back('{2'd2, 8'h13});
      wait_ready(g);
      compared++;
      if (g !== 4'b0100) begin
         mismatched++;
         $display("FAIL incr_grant: got %b, required 0100", g);
      end
      wait_done(4'b0100, n, c);
      compared++;
      if (n != 4 || c != 3) begin
         mismatched++;
         $display("FAIL incr3_timing: got latency=%0d cmd_cycles=%0d, required 4 3", n, c);
      end
      edge1();
      post(2, OP_INCR, 8'hF0);
      sbq.push_back('{2'd2, 8'h13});
      wait_ready(g);
      wait_done(4'b0100, n, c);
      compared++;
      if (n != 1 || c != 0) begin
         mismatched++;
         $display("FAIL incr0_timing: got latency=%0d cmd_cycles=%0d, required 1 0", n, c);
      end
   endtask
   task automatic test_round_robin();
      logic [NREQ-1:0] g;
      edge1();
      rst = 1'b1;
      edge1();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) post(i, OP_LOAD, 8'h40 + 8'(i));
      for (int i = 0; i < 5; i++) sbq.push_back('{IDW'(i % NREQ), 8'h40 + 8'(i % NREQ)});
      for (int i = 0; i < 5; i++) begin
         wait_ready(g);
         compared++;
         if (g !== 4'(1 << (i % NREQ))) begin
            mismatched++;
            $display("FAIL rr_order%0d: got %b, required %b", i, g, 4'(1 << (i % NREQ)));
         end
      end
      edge1();
      req_valid = '0;
      drain();
   endtask
   task automatic test_wrap();
      logic [NREQ-1:0] g;
      int n, c;
      edge1();
      post(3, OP_LOAD, 8'hFE);
      sbq.push_back('{2'd3, 8'hFE});
      wait_ready(g);
      wait_done(4'b1000, n, c);
      edge1();
      post(1, OP_INCR, 8'h05);
      sbq.push_back('{2'd1, 8'h03});
      wait_ready(g);
      wait_done(4'b0010, n, c);
      compared++;
      if (n != 6 || c != 5) begin
         mismatched++;
         $display("FAIL wrap_timing: got latency=%0d cmd_cycles=%0d, required 6 5", n, c);
      end
   endtask
   task automatic test_reset_mid();
      logic [NREQ-1:0] g;
      int n, c;
      edge1();
      post(0, OP_INCR, 8'h08);
      wait_ready(g);
      compared++;
      if (g !== 4'b0001) begin
         mismatched++;
         $display("FAIL mid_grant: got %b, required 0001", g);
      end
      edge1();
      req_valid = '0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      post(2, OP_LOAD, 8'h44);
      post(0, OP_LOAD, 8'h33);
      @(negedge clk);
      compared++;
      if (req_ready !== 4'b0000 || ctr_cmd !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_rst_pins: got ready=%b cmd=%b, required 0000 0", req_ready, ctr_cmd);
      end
      edge1();
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
         mismatched++;
         $display("FAIL mid_rst_state: got busy=%b done=%b result=%02h, required 0 0 00", busy, done, result);
      end
      edge1();
      rst = 1'b0;
      sbq.push_back('{2'd0, 8'h33});
      sbq.push_back('{2'd2, 8'h44});
      wait_ready(g);
      compared++;
      if (g !== 4'b0001) begin
         mismatched++;
         $display("FAIL post_rst_grant: got %b, required 0001", g);
      end
      wait_done(4'b0001, n, c);
      wait_ready(g);
      wait_done(4'b0100, n, c);
      drain();
   endtask
   task automatic test_withdraw();
      logic [NREQ-1:0] g;
      int n, c;
      logic saw1 = 1'b0;
      edge1();
      post(0, OP_LOAD, 8'h77);
      sbq.push_back('{2'd0, 8'h77});
      wait_ready(g);
      edge1();
      req_valid[0] = 1'b0;
      post(1, OP_LOAD, 8'h11);
      post(3, OP_LOAD, 8'h99);
      sbq.push_back('{2'd3, 8'h99});
      @(negedge clk);
      saw1 |= req_ready[1];
      edge1();
      req_valid[1] = 1'b0;
      wait_ready(g);
      compared++;
      if (g !== 4'b1000 || saw1 !== 1'b0) begin
         mismatched++;
         $display("FAIL withdraw: got grant=%b early_ready1=%b, required 1000 0", g, saw1);
      end
      wait_done(4'b1000, n, c);
      drain();
   endtask
   initial begin
      test_reset();
      test_load();
      test_incr();
      test_round_robin();
      test_wrap();
      test_reset_mid();
      test_withdraw();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
